alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 32-bit combinational ALU. Adds a registered output, valid/ready flow control, an iterative unsigned multiply and an illegal-opcode error flag.
- Sits between the decode stage and writeback in the lab datapath.
- Single-cycle ops complete in 1 cycle. MUL completes in WIDTH cycles.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, ≥4.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block accepts operation this cycle
- in_op  in  4  opcode (encoding below)
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer takes result this cycle
- out_result  out  WIDTH  result
- out_flags  out  4  {N,Z,C,V}
- out_err  out  1  illegal opcode for this result
- busy  out  1  multiply in progress

Behaviour:
- Opcodes:
  - 0000 ADD; 1000 SUB (a + ~b + 1)
  - 0111 AND; 0110 OR; 0100 XOR
  - 0010 GTS: 1 if a > b signed, else 0
  - 0011 GTU: 1 if a > b unsigned, else 0
  - 0001 SLL; 0101 SRL; 1101 SRA; shift amount = b[SHW-1:0], upper bits of b ignored
  - 1001 MUL: unsigned, low WIDTH bits of a*b
  - all others illegal
- Reset (async, rst_n=0): state=IDLE, out_valid=0, out_result=0, out_flags=0, out_err=0, busy=0. Any multiply in progress is discarded.
- States:
  - IDLE: output register empty or draining.
  - MUL: iterative shift-add; one partial product per cycle; counter runs 0..WIDTH-1.
  - HOLD: out_valid=1 and not drained.
- in_ready = (state != MUL) && (!out_valid || out_ready). An accept is in_valid && in_ready.
- Accept of a non-MUL op: result, flags and err are registered at the next edge, so out_valid=1 in the following cycle (latency 1). Back-to-back accepts give full throughput while out_ready=1.
- Accept of MUL: out_valid drops to 0 if it was being drained. Enter MUL, busy=1. After WIDTH cycles in MUL, the result is registered, out_valid=1, busy=0 (accept-to-out_valid latency WIDTH+1 cycles).
- out_valid stays asserted and out_result/out_flags/out_err stay stable until out_ready=1. Drain and new accept in the same cycle are permitted (not during MUL).
- Flags:
  - N = result[WIDTH-1]; Z = (result==0).
  - ADD/SUB: C = carry-out of the WIDTH+1-bit sum (SUB: C=1 means no borrow); V = signed overflow.
  - MUL: C = 1 if any bit of the upper half of the 2*WIDTH product is nonzero; V=0.
  - All other ops: C=V=0.
- GTS/GTU are computed from an internal a−b. Result is zero-extended to WIDTH.
- Illegal op: out_result=0, out_flags=0, out_err=1, latency 1. The block must never latch or hang on an illegal op.
- No combinational path from in_* to out_*. in_ready depends only on state, out_valid and out_ready.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum of the 4-bit opcodes
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - state enum alu_state_e
- Sub-module alu_comb (WIDTH-parametrised, purely combinational) computes result, flags and err for all single-cycle ops.
- The multiplier datapath and FSM live in alu_seq.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF b=1, out_ready=1 -> next cycle out_result=0x80000000, flags N=1 Z=0 C=0 V=1.
- SUB a=5 b=5 -> result 0, flags {0,1,1,0}. GTS a=0xFFFFFFFF b=1 -> 0. GTU a=0xFFFFFFFF b=1 -> 1.
- SRA a=0x80000000 b=0x24 (shift 4) -> 0xF8000000. SRL same inputs -> 0x08000000. SLL a=1 b=31 -> 0x80000000.
- MUL a=0x10000 b=0x10000 -> busy=1 and in_ready=0 for 32 cycles; out_valid on the 33rd cycle after accept; result 0, C=1, Z=1.
- Backpressure: out_ready=0 for 5 cycles after an ADD -> out_valid held, output stable, in_ready=0. Then out_ready=1 with a new in_valid -> drain and accept in the same cycle, no gap.
- Illegal op 1111 -> out_err=1, result 0. Then assert rst_n=0 mid-MUL (cycle 10) -> all outputs 0 immediately; after release, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: opcode encoding, flag bit
// positions inside the {N,Z,C,V} flag vector, and the controller states.
// No ports; imported by alu_comb and alu_seq.
// -----------------------------------------------------------------------------
package alu_pkg;

    // 4-bit opcode map. Every encoding not listed here is illegal.
    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SLL = 4'b0001,
        OP_GTS = 4'b0010,
        OP_GTU = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SRL = 4'b0101,
        OP_OR  = 4'b0110,
        OP_AND = 4'b0111,
        OP_SUB = 4'b1000,
        OP_MUL = 4'b1001,
        OP_SRA = 4'b1101
    } alu_op_e;

    // Bit positions of the flags in out_flags = {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // ST_IDLE: result register empty (or just drained)
    // ST_MUL : iterative multiply running
    // ST_HOLD: result register valid, waiting for the consumer
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_HOLD = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_comb.sv
// -----------------------------------------------------------------------------
// alu_comb
// Purely combinational datapath for every single-cycle opcode. MUL is
// recognised as legal but produces nothing here; the multiplier lives in
// alu_seq.
// Ports:
//   op     in   4      opcode
//   a, b   in   WIDTH  operands
//   result out  WIDTH  result (0 for illegal ops and MUL)
//   flags  out  4      {N,Z,C,V} (0 for illegal ops)
//   err    out  1      opcode is illegal
// -----------------------------------------------------------------------------
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    alu_op_e          op_e;
    logic [SHW-1:0]   shamt;
    logic             is_sub;
    logic [WIDTH-1:0] b_add;
    logic [WIDTH:0]   sum;
    logic             sum_v;
    logic             sum_nz;
    logic             gtu;
    logic             gts;

    assign op_e  = alu_op_e'(op);
    assign shamt = b[SHW-1:0];

    // One shared adder: ADD uses a+b, while SUB, GTS and GTU all use a-b
    // formed as a + ~b + 1. The top bit of the WIDTH+1 sum is the carry,
    // which for subtraction means "no borrow".
    assign is_sub = (op_e != OP_ADD);
    assign b_add  = is_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, is_sub};
    assign sum_v  = (a[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sum_nz = (sum[WIDTH-1:0] != '0);

    // a > b unsigned: no borrow and a != b.
    // a > b signed:   difference non-negative after overflow correction and a != b.
    assign gtu = sum[WIDTH] && sum_nz;
    assign gts = !(sum[WIDTH-1] ^ sum_v) && sum_nz;

    always_comb begin
        logic c;
        logic v;
        result = '0;
        err    = 1'b0;
        c      = 1'b0;
        v      = 1'b0;
        flags  = '0;
        case (op_e)
            OP_ADD, OP_SUB: begin
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                v      = sum_v;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_GTS: result = {{(WIDTH-1){1'b0}}, gts};
            OP_GTU: result = {{(WIDTH-1){1'b0}}, gtu};
            OP_SLL: result = a << shamt;
            OP_SRL: result = a >> shamt;
            OP_SRA: result = $unsigned($signed(a) >>> shamt);
            OP_MUL: result = '0;
            default: err   = 1'b1;
        endcase
        if (!err) begin
            flags[FLAG_N] = result[WIDTH-1];
            flags[FLAG_Z] = (result == '0);
            flags[FLAG_C] = c;
            flags[FLAG_V] = v;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Handshaked ALU with a registered result. Single-cycle ops come from
// alu_comb and appear one cycle after accept; MUL is an unsigned shift-add
// multiplier taking WIDTH cycles in ST_MUL.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    operation handshake; in_op, in_a, in_b operands
//   out_valid/out_ready  result handshake; out_result, out_flags {N,Z,C,V},
//                        out_err (illegal opcode)
//   busy                 multiply in progress
// -----------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             out_err,
    output logic             busy
);

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    alu_state_e         state;
    alu_state_e         state_next;
    logic               accept;
    logic               is_mul_op;
    logic               mul_last;

    logic [WIDTH-1:0]   comb_result;
    logic [3:0]         comb_flags;
    logic               comb_err;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic [3:0]         mul_flags;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .result (comb_result),
        .flags  (comb_flags),
        .err    (comb_err)
    );

    // out_valid is exactly "in ST_HOLD", so in_ready depends only on
    // registered state and out_ready, never on in_*.
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state == ST_MUL);
    assign in_ready  = (state != ST_MUL) && ((state != ST_HOLD) || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul_op = (in_op == OP_MUL);
    assign mul_last  = (state == ST_MUL) && (cnt == CNT_LAST);

    // One partial product per cycle: add the shifted multiplicand when the
    // current multiplier LSB is set. The full 2*WIDTH product is kept so the
    // carry flag can report a nonzero upper half.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_N] = acc_next[WIDTH-1];
        mul_flags[FLAG_Z] = (acc_next[WIDTH-1:0] == '0);
        mul_flags[FLAG_C] = (acc_next[2*WIDTH-1:WIDTH] != '0);
        mul_flags[FLAG_V] = 1'b0;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    state_next = is_mul_op ? ST_MUL : ST_HOLD;
                end else if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    state_next = ST_HOLD;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Result register and multiplier datapath. A MUL accept leaves the old
    // result in place; out_valid drops through the state change alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_flags  <= '0;
            out_err    <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
        end else begin
            if (accept && !is_mul_op) begin
                out_result <= comb_result;
                out_flags  <= comb_flags;
                out_err    <= comb_err;
            end
            if (accept && is_mul_op) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, in_a};
                mplier <= in_b;
                cnt    <= '0;
            end else if (state == ST_MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (mul_last) begin
                    out_result <= acc_next[WIDTH-1:0];
                    out_flags  <= mul_flags;
                    out_err    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq at WIDTH=32: a table of directed vectors,
// hand-written sequences for multiply timing, backpressure and reset, and
// random operations compared with a behavioural model.
// -----------------------------------------------------------------------------
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [3:0]    out_flags;
    logic          out_err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flags;
        logic         err;
    } vec_t;

    vec_t vecs[18];

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_err    (out_err),
        .busy       (busy)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case the design stops responding entirely
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    // Behavioural reference: plain wide arithmetic from the opcode definitions
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [3:0] f, output logic e);
        logic [63:0] wide;
        longint      s;
        logic        c;
        logic        v;
        logic [4:0]  sh;
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        e  = 1'b0;
        sh = b[4:0];
        case (op)
            4'b0000: begin
                wide = {32'b0, a} + {32'b0, b};
                r = wide[31:0];
                c = wide[32];
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b1000: begin
                r = a - b;
                c = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: r = a & b;
            4'b0110: r = a | b;
            4'b0100: r = a ^ b;
            4'b0010: r = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a > b) ? 32'd1 : 32'd0;
            4'b0001: r = a << sh;
            4'b0101: r = a >> sh;
            4'b1101: r = $unsigned($signed(a) >>> sh);
            4'b1001: begin
                wide = 64'(a) * 64'(b);
                r = wide[31:0];
                c = (wide[63:32] != 32'd0);
            end
            default: e = 1'b1;
        endcase
        f = e ? 4'b0000 : {r[31], (r == 32'd0), c, v};
    endfunction

    // Present one operation, wait for its accept, then wait for the result.
    // lat counts extra cycles after the accept edge before out_valid shows.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic [3:0] f, output logic e,
                                 output int lat);
        int budget;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        budget    = 0;
        while (!in_ready && budget < 100) begin
            step();
            budget++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready got 0, expected 1");
        end
        step();
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        lat      = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout: out_valid got 0, expected 1");
        end
        r = out_result;
        f = out_flags;
        e = out_err;
    endtask

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] mr;
        logic [3:0]   f;
        logic [3:0]   mf;
        logic         e;
        logic         me;
        int           lat;
        logic [3:0]   legal_ops[11];
        logic [3:0]   bad_ops[5];

        vecs[0]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001, 1'b0};
        vecs[1]  = '{OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110, 1'b0};
        vecs[2]  = '{OP_GTS, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0100, 1'b0};
        vecs[3]  = '{OP_GTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000, 1'b0};
        vecs[4]  = '{OP_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 4'b1000, 1'b0};
        vecs[5]  = '{OP_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 4'b0000, 1'b0};
        vecs[6]  = '{OP_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 4'b1000, 1'b0};
        vecs[7]  = '{OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b0110, 1'b0};
        vecs[8]  = '{4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 4'b0000, 1'b1};
        vecs[9]  = '{OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000, 1'b0};
        vecs[10] = '{OP_OR,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100, 1'b0};
        vecs[11] = '{OP_XOR, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 4'b1000, 1'b0};
        vecs[12] = '{OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000, 1'b0};
        vecs[13] = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 1'b0};
        vecs[14] = '{OP_MUL, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 4'b0000, 1'b0};
        vecs[15] = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 1'b0};
        vecs[16] = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011, 1'b0};
        vecs[17] = '{4'b1010, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 4'b0000, 1'b1};

        legal_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_GTS, OP_GTU,
                      OP_SLL, OP_SRL, OP_SRA, OP_MUL};
        bad_ops   = '{4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b1111};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        step();
        step();

        // Reset state
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_result", out_result, 32'd0);
        checkOutput("rst_flags", 32'(out_flags), 32'd0);
        checkOutput("rst_err", 32'(out_err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, r, f, e, lat);
            checkOutput($sformatf("vec%0d_result", i), r, vecs[i].res);
            checkOutput($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].flags));
            checkOutput($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat),
                        (vecs[i].op == OP_MUL) ? 32'd32 : 32'd0);
        end

        // Multiply window: busy high and in_ready low for exactly 32 cycles
        step();
        in_op     = OP_MUL;
        in_a      = 32'h0001_0000;
        in_b      = 32'h0001_0000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        checkOutput("mul_pre_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("mul_window_c%0d", i + 1), 32'({busy, in_ready, out_valid}), 32'b100);
            step();
        end
        checkOutput("mul_done_valid", 32'({busy, out_valid}), 32'b01);
        checkOutput("mul_done_result", out_result, 32'd0);
        checkOutput("mul_done_flags", 32'(out_flags), 32'b0110);

        // Backpressure: ADD result must hold while out_ready is low
        step();
        in_op     = OP_ADD;
        in_a      = 32'd100;
        in_b      = 32'd23;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_op = OP_SUB;
        in_a  = 32'd50;
        in_b  = 32'd8;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_valid_c%0d", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp_result_c%0d", i), out_result, 32'd123);
            checkOutput($sformatf("bp_in_ready_c%0d", i), 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        checkOutput("bp_nogap_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_nogap_result", out_result, 32'd42);

        // Reset in the middle of a multiply
        applyStimulus(OP_ADD, 32'h0000_1234, 32'h0000_0001, r, f, e, lat);
        checkOutput("prerst_result", r, 32'h0000_1235);
        in_op    = OP_MUL;
        in_a     = 32'd7;
        in_b     = 32'd9;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        checkOutput("midmul_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_result", out_result, 32'd0);
        checkOutput("midrst_flags", 32'(out_flags), 32'd0);
        checkOutput("midrst_err", 32'(out_err), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        checkOutput("postrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 35; i++) step();
        checkOutput("postrst_no_stale_mul", 32'({busy, out_valid}), 32'b00);

        // Random operations against the behavioural model
        for (int i = 0; i < 150; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 4)];
            else                           op = legal_ops[$urandom_range(0, 10)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            model(op, a, b, mr, mf, me);
            applyStimulus(op, a, b, r, f, e, lat);
            checkOutput($sformatf("rand%0d_op%h_result", i, op), r, mr);
            checkOutput($sformatf("rand%0d_op%h_flags", i, op), 32'(f), 32'(mf));
            checkOutput($sformatf("rand%0d_op%h_err", i, op), 32'(e), 32'(me));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
